// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a 32-bit word memory, misaligned accesses split over two words.
// Latency: response strobe two cycles after accept (three when the access spans two words).
// Backpressure: req_ready is high only while idle; one request in flight at a time.
module load_store_unit #(
  parameter int MEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

  // Word indices are 30 bits; widen by one so the bound compare cannot wrap.
  localparam logic [30:0] MEM_LIM = 31'(MEM_WORDS);

  state_t      state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic [29:0] word0_q;
  logic [29:0] word1_q;
  logic        split_q;
  logic        err_q;
  logic [7:0]  lane_mask_q;
  logic [31:0] lo_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  // Request decode, evaluated on the request inputs at capture time.
  logic [2:0]  size_d;
  logic [2:0]  span_d;
  logic        split_d;
  logic [29:0] word0_d;
  logic [29:0] word1_d;
  logic        bad_f3_d;
  logic        bad_store_d;
  logic        oob_d;
  logic        err_d;
  logic [7:0]  lane_mask_d;
  logic [31:0] wdata_rot;

  // Extract the addressed bytes from the {hi,lo} pair and extend per funct3.
  function automatic logic [31:0] load_fmt(input logic [31:0] hi, input logic [31:0] lo,
                                           input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] s;
    s = 32'({hi, lo} >> {off, 3'b000});
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'd0, s[7:0]};
      3'b101:  return {16'd0, s[15:0]};
      default: return s;
    endcase
  endfunction

  // Decode size, split, range and legality of the presented request.
  always_comb begin
    case (req_funct3[1:0])
      2'b00:   size_d = 3'd1;
      2'b01:   size_d = 3'd2;
      default: size_d = 3'd4;
    endcase
    span_d      = {1'b0, req_addr[1:0]} + size_d;
    split_d     = (span_d > 3'd4);
    word0_d     = req_addr[31:2];
    word1_d     = word0_d + 30'd1;
    bad_f3_d    = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    bad_store_d = req_we && ((req_funct3 == 3'b100) || (req_funct3 == 3'b101));
    // word1 only matters when split; a wrapping word1 implies word0 is already out of range.
    oob_d       = ({1'b0, word0_d} >= MEM_LIM) || (split_d && ({1'b0, word1_d} >= MEM_LIM));
    err_d       = bad_f3_d || bad_store_d || oob_d;
    // Low nibble = lanes in word0, high nibble = lanes spilling into word1.
    lane_mask_d = ((8'd1 << size_d) - 8'd1) << req_addr[1:0];
  end

  // Rotate store data so byte 0 lands in lane off_q; wrapped bytes feed word1.
  always_comb begin
    case (off_q)
      2'd0:    wdata_rot = wdata_q;
      2'd1:    wdata_rot = {wdata_q[23:0], wdata_q[31:24]};
      2'd2:    wdata_rot = {wdata_q[15:0], wdata_q[31:16]};
      default: wdata_rot = {wdata_q[7:0],  wdata_q[31:8]};
    endcase
  end

  // Memory port drive from the current state; reset forces write enables off immediately.
  always_comb begin
    req_ready = (state_q == IDLE);
    mem_addr  = 32'd0;
    mem_we    = 4'b0000;
    mem_wdata = 32'd0;
    case (state_q)
      ACC1: begin
        mem_addr  = {2'b00, word0_q};
        mem_wdata = wdata_rot;
        if (we_q && !err_q) mem_we = lane_mask_q[3:0];
      end
      ACC2: begin
        mem_addr  = {2'b00, word1_q};
        mem_wdata = wdata_rot;
        if (we_q && !err_q) mem_we = lane_mask_q[7:4];
      end
      default: ;
    endcase
    if (rst) mem_we = 4'b0000;
  end

  // Access sequencer: capture, one or two memory beats, single-cycle response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      wdata_q     <= 32'd0;
      word0_q     <= 30'd0;
      word1_q     <= 30'd0;
      split_q     <= 1'b0;
      err_q       <= 1'b0;
      lane_mask_q <= 8'd0;
      lo_q        <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            funct3_q    <= req_funct3;
            off_q       <= req_addr[1:0];
            wdata_q     <= req_wdata;
            word0_q     <= word0_d;
            word1_q     <= word1_d;
            split_q     <= split_d;
            err_q       <= err_d;
            lane_mask_q <= lane_mask_d;
            state_q     <= ACC1;
          end
        end
        ACC1: begin
          lo_q <= mem_rdata;
          if (split_q && !err_q) begin
            state_q <= ACC2;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q;
            rsp_rdata_q <= (we_q || err_q) ? 32'd0 : load_fmt(32'd0, mem_rdata, off_q, funct3_q);
          end
        end
        ACC2: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= we_q ? 32'd0 : load_fmt(mem_rdata, lo_q, off_q, funct3_q);
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model, response scoreboard, per-feature scenario tasks.
// Latency: responses checked against the cycle they are due.
// Backpressure: requests issued only when req_ready is high.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int assertions = 0;
  int failures   = 0;
  int cyc        = 0;
  logic we_seen  = 1'b0;

  logic [31:0] mem [0:127];
  logic [7:0]  shadow [0:511];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  load_store_unit #(.MEM_WORDS(128)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = (mem_addr < 32'd128) ? mem[mem_addr[6:0]] : 32'd0;

  // Memory model: byte-lane writes, plus a sticky flag for any write strobe.
  always @(posedge clk) begin
    if (mem_we != 4'b0000) we_seen = 1'b1;
    for (int k = 0; k < 4; k++)
      if (mem_we[k] && mem_addr < 32'd128) mem[mem_addr[6:0]][8*k +: 8] = mem_wdata[8*k +: 8];
  end

  // Scoreboard: every response strobe must match the oldest expectation, on its due cycle.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      assertions++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp err=%b rdata=%h cyc=%0d, none expected", rsp_err, rsp_rdata, cyc);
      end else begin
        mon_e = q.pop_front();
        if (rsp_err !== mon_e.err || rsp_rdata !== mon_e.rdata || cyc !== mon_e.due) begin
          failures++;
          $display("FAIL rsp got err=%b rdata=%h cyc=%0d expected err=%b rdata=%h cyc=%0d",
                   rsp_err, rsp_rdata, cyc, mon_e.err, mon_e.rdata, mon_e.due);
        end
      end
    end
  end

  // Issue one request when ready; lat>0 queues the expected response lat cycles after accept.
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rdata,
                      input int lat);
    int guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    assertions++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL req_ready_timeout got=%b expected=1", req_ready);
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (lat > 0) begin
      e.err   = exp_err;
      e.rdata = exp_rdata;
      e.due   = cyc + lat;
      q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    assertions++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d expected=0", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    assertions++;
    if (mem_we !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mem_we got=%b expected=0000", mem_we);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    assertions++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0 || mem_addr !== 32'd0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b rdata=%h err=%b addr=%h expected 1 0 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr);
    end
  endtask

  task automatic test_store_word;
    mem[2] = 32'h0;
    send(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 1'b0, 32'h0, 1);
    @(negedge clk);
    assertions++;
    if (mem_addr !== 32'd2 || mem_we !== 4'b1111 || mem_wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL sw_acc1 got addr=%h we=%b wdata=%h expected 2 1111 deadbeef", mem_addr, mem_we, mem_wdata);
    end
    @(negedge clk);
    assertions++;
    if (mem_addr !== 32'd0 || mem_we !== 4'b0000) begin
      failures++;
      $display("FAIL sw_resp_port got addr=%h we=%b expected 0 0000", mem_addr, mem_we);
    end
    drain("sw");
    assertions++;
    if (mem[2] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL sw_mem got=%h expected=deadbeef", mem[2]);
    end
  endtask

  task automatic test_store_byte;
    mem[1] = 32'h11223344;
    send(1'b1, 3'b000, 32'h5, 32'h000000A5, 1'b0, 32'h0, 1);
    @(negedge clk);
    assertions++;
    if (mem_addr !== 32'd1 || mem_we !== 4'b0010 || mem_wdata !== 32'h0000A500) begin
      failures++;
      $display("FAIL sb_acc1 got addr=%h we=%b wdata=%h expected 1 0010 0000a500", mem_addr, mem_we, mem_wdata);
    end
    drain("sb");
    assertions++;
    if (mem[1] !== 32'h1122A544) begin
      failures++;
      $display("FAIL sb_mem got=%h expected=1122a544", mem[1]);
    end
  endtask

  task automatic test_load_ext;
    mem[1] = 32'h80010000;
    send(1'b0, 3'b001, 32'h6, 32'h0, 1'b0, 32'hFFFF8001, 1);
    send(1'b0, 3'b101, 32'h6, 32'h0, 1'b0, 32'h00008001, 1);
    send(1'b0, 3'b000, 32'h7, 32'h0, 1'b0, 32'hFFFFFF80, 1);
    send(1'b0, 3'b100, 32'h7, 32'h0, 1'b0, 32'h00000080, 1);
    send(1'b0, 3'b100, 32'h4, 32'h0, 1'b0, 32'h00000000, 1);
    send(1'b0, 3'b010, 32'h4, 32'h0, 1'b0, 32'h80010000, 1);
    drain("load_ext");
  endtask

  task automatic test_split;
    mem[0] = 32'h44332211;
    mem[1] = 32'h88776655;
    send(1'b0, 3'b010, 32'h3, 32'h0, 1'b0, 32'h77665544, 2);
    @(negedge clk);
    assertions++;
    if (mem_addr !== 32'd0 || mem_we !== 4'b0000) begin
      failures++;
      $display("FAIL lw_split_acc1 got addr=%h we=%b expected 0 0000", mem_addr, mem_we);
    end
    @(negedge clk);
    assertions++;
    if (mem_addr !== 32'd1 || mem_we !== 4'b0000) begin
      failures++;
      $display("FAIL lw_split_acc2 got addr=%h we=%b expected 1 0000", mem_addr, mem_we);
    end
    drain("lw_split");
    repeat (2) @(negedge clk);
    assertions++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h77665544) begin
      failures++;
      $display("FAIL rsp_hold got vld=%b rdata=%h expected 0 77665544", rsp_valid, rsp_rdata);
    end
    send(1'b0, 3'b101, 32'h3, 32'h0, 1'b0, 32'h00005544, 2);
    send(1'b1, 3'b010, 32'h3, 32'hAABBCCDD, 1'b0, 32'h0, 2);
    @(negedge clk);
    assertions++;
    if (mem_addr !== 32'd0 || mem_we !== 4'b1000 || mem_wdata !== 32'hDDAABBCC) begin
      failures++;
      $display("FAIL sw_split_acc1 got addr=%h we=%b wdata=%h expected 0 1000 ddaabbcc", mem_addr, mem_we, mem_wdata);
    end
    @(negedge clk);
    assertions++;
    if (mem_addr !== 32'd1 || mem_we !== 4'b0111 || mem_wdata !== 32'hDDAABBCC) begin
      failures++;
      $display("FAIL sw_split_acc2 got addr=%h we=%b wdata=%h expected 1 0111 ddaabbcc", mem_addr, mem_we, mem_wdata);
    end
    drain("sw_split");
    assertions++;
    if (mem[0] !== 32'hDD332211 || mem[1] !== 32'h88AABBCC) begin
      failures++;
      $display("FAIL sw_split_mem got %h %h expected dd332211 88aabbcc", mem[0], mem[1]);
    end
  endtask

  task automatic test_errors;
    mem[127] = 32'hCAFEF00D;
    we_seen = 1'b0;
    send(1'b0, 3'b010, 32'h1FE, 32'h0, 1'b1, 32'h0, 1);
    send(1'b0, 3'b011, 32'h0, 32'h0, 1'b1, 32'h0, 1);
    send(1'b1, 3'b100, 32'h10, 32'h12345678, 1'b1, 32'h0, 1);
    send(1'b1, 3'b010, 32'h1FE, 32'h12345678, 1'b1, 32'h0, 1);
    send(1'b1, 3'b000, 32'h200, 32'h12345678, 1'b1, 32'h0, 1);
    drain("errors");
    assertions++;
    if (we_seen !== 1'b0 || mem[127] !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL err_no_write got we_seen=%b mem127=%h expected 0 cafef00d", we_seen, mem[127]);
    end
    send(1'b0, 3'b010, 32'h1FC, 32'h0, 1'b0, 32'hCAFEF00D, 1);
    send(1'b0, 3'b000, 32'h1FF, 32'h0, 1'b0, 32'hFFFFFFCA, 1);
    drain("last_word");
  endtask

  task automatic test_reset_mid;
    mem[0] = 32'h44332211;
    mem[1] = 32'h88776655;
    send(1'b1, 3'b010, 32'h3, 32'hAABBCCDD, 1'b0, 32'h0, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    assertions++;
    if (mem_we !== 4'b0000) begin
      failures++;
      $display("FAIL rst_acc2_we got=%b expected=0000", mem_we);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    assertions++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem[1] !== 32'h88776655) begin
      failures++;
      $display("FAIL rst_abort got rdy=%b vld=%b mem1=%h expected 1 0 88776655", req_ready, rsp_valid, mem[1]);
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [31:0] model_load(input int addr, input logic [2:0] f3);
    int n;
    logic [31:0] v;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    v = 32'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = shadow[addr + i];
    if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFFFF00;
    if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic test_back_to_back;
    logic [2:0] ld_f3 [5];
    int addr, n, lat;
    logic we, err;
    logic [2:0] f3;
    logic [31:0] wd, exp_r;
    int bad;
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int w = 0; w < 128; w++) begin
      mem[w] = $urandom;
      for (int b = 0; b < 4; b++) shadow[4*w + b] = mem[w][8*b +: 8];
    end
    for (int t = 0; t < 60; t++) begin
      we   = ($urandom_range(0, 2) == 0);
      f3   = we ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      addr = (t % 10 == 0) ? 510 + (t % 3) : int'($urandom_range(0, 511));
      n    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      wd   = $urandom;
      err  = (addr + n - 1 > 511);
      lat  = (!err && ((addr % 4) + n > 4)) ? 2 : 1;
      exp_r = (we || err) ? 32'd0 : model_load(addr, f3);
      if (we && !err)
        for (int i = 0; i < n; i++) shadow[addr + i] = wd[8*i +: 8];
      send(we, f3, 32'(addr), wd, err, exp_r, lat);
    end
    drain("b2b");
    bad = 0;
    for (int w = 0; w < 128; w++)
      for (int b = 0; b < 4; b++)
        if (mem[w][8*b +: 8] !== shadow[4*w + b]) bad++;
    assertions++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_mem_image got %0d differing bytes expected 0", bad);
    end
  endtask

  initial begin
    for (int w = 0; w < 128; w++) mem[w] = 32'd0;
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_ext();
    test_split();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001: Parameter MEM_WORDS, default 128, meaning data-memory depth in 32-bit words; legal word indices are 0..MEM_WORDS-1.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: rst  input  1  reset, synchronous, active-high.
REQ-004: req_valid  input  1  core presents a load/store request.
REQ-005: req_ready  output  1  unit can accept a request.
REQ-006: req_we  input  1  1 = store, 0 = load.
REQ-007: req_funct3  input  3  RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008: req_addr  input  32  byte address.
REQ-009: req_wdata  input  32  store data, right-aligned.
REQ-010: rsp_valid  output  1  one-cycle response strobe.
REQ-011: rsp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-012: rsp_err  output  1  request rejected; valid with rsp_valid.
REQ-013: mem_addr  output  32  word index to data memory.
REQ-014: mem_we  output  4  byte-lane write enables, lane k = bits 8k+7:8k.
REQ-015: mem_wdata  output  32  lane-aligned write data.
REQ-016: mem_rdata  input  32  memory read data, combinational from mem_addr (same cycle).

Function
REQ-017: FSM states IDLE, ACC1, ACC2, RESP; req_ready = 1 only in IDLE.
REQ-018: IDLE, req_valid=1 -> capture req_we, req_funct3, req_addr, req_wdata; go ACC1. Otherwise stay IDLE.
REQ-019: Offset o = addr[1:0], size n = 1/2/4 bytes from funct3; word0 = addr>>2; access is split when o+n > 4, with word1 = word0+1.
REQ-020: Error at capture when funct3 is in {011,110,111}, or store with funct3 in {100,101}, or any touched word index >= MEM_WORDS; evaluated once for both words, so no partial write ever occurs.
REQ-021: ACC1 drives mem_addr = word0 and captures mem_rdata as lo. Next state is ACC2 if split and no error, else RESP.
REQ-022: ACC2 drives mem_addr = word1 and captures mem_rdata as hi. Next state is RESP.
REQ-023: mem_wdata = req_wdata rotated left by 8*o bits, in both ACC1 and ACC2.
REQ-024: ACC1 store: mem_we lanes o..min(o+n,4)-1 set.
REQ-025: ACC2 store: mem_we lanes 0..o+n-5 set.
REQ-026: mem_we = 0000 for loads, errors, IDLE and RESP, and whenever rst=1 (combinational override).
REQ-027: mem_addr = 0 in IDLE and RESP.
REQ-028: Load result formation:
  - Take {hi,lo}, shift right by 8*o, keep the low n bytes.
  - B/H sign-extend; BU/HU zero-extend; W unchanged.
REQ-029: RESP asserts rsp_valid for exactly one cycle with rsp_rdata and rsp_err, then returns to IDLE.
REQ-030: rsp_rdata/rsp_err are held registers, stable outside RESP; a new request is accepted no earlier than the cycle after RESP.
REQ-031: Latency from accept edge T:
  - Non-split or error: ACC1 at T+1, rsp_valid at T+2.
  - Split: ACC2 at T+2, rsp_valid at T+3.
REQ-032: Word index arithmetic is 30-bit unsigned; word1 never wraps to 0 (the range check in REQ-020 catches it).

Reset
REQ-033: While rst=1 at a clock edge, next state = IDLE and rsp_valid, rsp_rdata, rsp_err, and all captured registers become 0.
REQ-034: Reset in any state (including mid-split store) aborts the request without a response; req_ready = 1 on the first cycle after rst deasserts.

Verification
REQ-035: SW addr 0x8, wdata 0xDEADBEEF -> ACC1 mem_addr=2, mem_we=1111, mem_wdata=0xDEADBEEF; rsp_valid at T+2, err=0, rdata=0.
REQ-036: SB addr 0x5, wdata 0x000000A5 -> mem_addr=1, mem_we=0010, mem_wdata=0x0000A500.
REQ-037: Word 1 = 0x80010000:
  - LH addr 0x6 -> rdata 0xFFFF8001.
  - LHU addr 0x6 -> rdata 0x00008001.
REQ-038: Word0=0x44332211, word1=0x88776655:
  - LW addr 0x3 -> mem_addr 0 then 1, rdata 0x77665544 at T+3.
  - SW addr 0x3, wdata 0xAABBCCDD -> ACC1 we=1000, wdata=0xDDAABBCC; ACC2 we=0111, wdata=0xDDAABBCC.
REQ-039: MEM_WORDS=128, errors:
  - LW addr 0x1FE -> err=1, rdata=0, mem_we never nonzero.
  - funct3=011 -> same response.
REQ-040: rst pulsed during ACC2 of split SW addr 0x3 -> mem_we=0000 in that cycle, no rsp_valid, req_ready=1 after release.
